fetch_queue: RTL and testbench

- Parametrised successor of the single-entry fetch stage.
- Holds the PC and drives a combinational imem read port with it.
- Predecodes each word for branch prediction and pushes {insnbits, pc, pred_taken} into a QDEPTH-entry FIFO.
- The FIFO drains to decode over a valid/ready handshake, and a redirect port from execute (mispredict, RET) flushes it and steers the PC.

---
 rtl/fetch_queue_if.sv | 17 +
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-to-decode handshake; master is the fetch queue, slave is decode.
interface fetch_queue_if;
    logic        out_d_valid;
    logic        in_d_ready;
    logic [31:0] out_d_insnbits;
    logic [63:0] out_d_pc;
    logic        out_d_pred_taken;
    logic        out_d_done;
    modport master (
        output out_d_valid, out_d_insnbits, out_d_pc, out_d_pred_taken, out_d_done,
        input  in_d_ready
    );
    modport slave (
        input  out_d_valid, out_d_insnbits, out_d_pc, out_d_pred_taken, out_d_done,
        output in_d_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: PC + branch predecode feeding a QDEPTH-entry FIFO to decode, with execute redirect.
// Define FETCH_BCOND_PREDICT_EN to predict backward B.cond taken (BTFN); otherwise B.cond is not-taken.
module fetch_queue #(
    parameter int          PAGESIZE = 4096,
    parameter int          QDEPTH   = 4,
    parameter logic [63:0] ENTRY_PC = 64'h0
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    output logic [63:0]          out_imem_addr,
    input  logic [31:0]          in_imem_data,
    input  logic                 in_redirect_valid,
    input  logic [63:0]          in_redirect_pc,
    fetch_queue_if.master        d
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(QDEPTH);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || PAGESIZE < 4) begin : g_bad_cfg
        $error("fetch_queue: QDEPTH must be a power of two >= 2 and PAGESIZE >= 4");
    end

    logic [63:0]       pc;
    logic              halted;
    logic [AW-1:0]     head, tail;
    logic [AW:0]       count;
    logic [31:0]       insn_q [QDEPTH];
    logic [63:0]       pc_q   [QDEPTH];
    logic [QDEPTH-1:0] pred_q;
    logic              valid, is_b, pred, pop, push, halt;
    logic [63:0]       b_tgt, bc_tgt, next_pc;

    always_comb begin
        is_b    = (in_imem_data[31:26] == 6'b000101) | (in_imem_data[31:26] == 6'b100101);
        b_tgt   = pc + {{36{in_imem_data[25]}}, in_imem_data[25:0], 2'b00};
        bc_tgt  = pc + {{43{in_imem_data[23]}}, in_imem_data[23:5], 2'b00};
`ifdef FETCH_BCOND_PREDICT_EN
        pred    = is_b | ((in_imem_data[31:24] == 8'h54) & in_imem_data[23]);
`else
        pred    = is_b;
`endif
        next_pc = !pred ? pc + 64'd4 : is_b ? b_tgt : bc_tgt;
        valid   = count != '0;
        pop     = valid & d.in_d_ready;
        push    = !halted & !in_redirect_valid & ((count != CAP) | pop) & (in_imem_data != '0);
        halt    = !halted & !in_redirect_valid & (in_imem_data == '0);
    end

    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) begin
            pc     <= ENTRY_PC;
            halted <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else if (in_redirect_valid) begin
            pc     <= in_redirect_pc;
            halted <= 1'b0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
        end else begin
            if (push) pc <= next_pc;
            if (halt) halted <= 1'b1;
            if (pop) head <= head + AW'(1);
            if (push) tail <= tail + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end

    // Storage needs no reset: every read is gated by count.
    always_ff @(posedge in_clk)
        if (push) begin
            insn_q[tail] <= in_imem_data;
            pc_q[tail]   <= pc;
            pred_q[tail] <= pred;
        end

    assign out_imem_addr      = pc;
    assign d.out_d_valid      = valid;
    assign d.out_d_insnbits   = valid ? insn_q[head] : '0;
    assign d.out_d_pc         = valid ? pc_q[head] : '0;
    assign d.out_d_pred_taken = valid & pred_q[head];
    assign d.out_d_done       = halted & !valid;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-based reference model checked every cycle.
module tb_fetch_queue;
    localparam int          QD  = 4;
    localparam logic [63:0] EPC = 64'h0;
    localparam logic [31:0] ADD = 32'h8B020020;
`ifdef FETCH_BCOND_PREDICT_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redir_v = 1'b0;
    logic [63:0] redir_pc = '0;
    logic [31:0] imem [1024];
    int          checks = 0, errors = 0;

    logic [63:0] mpc;
    logic        mhalt;
    logic [96:0] mq [$];

    fetch_queue_if dif ();

    fetch_queue #(.PAGESIZE(4096), .QDEPTH(QD), .ENTRY_PC(EPC)) dut (
        .in_clk(clk), .in_rst_n(rst_n),
        .out_imem_addr(imem_addr), .in_imem_data(imem_data),
        .in_redirect_valid(redir_v), .in_redirect_pc(redir_pc),
        .d(dif)
    );

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr[11:2]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc   = EPC;
        mhalt = 1'b0;
    endtask

    // Prediction straight from the ISA rules using signed offsets.
    task automatic predict(input logic [31:0] w, input logic [63:0] p, output logic pr, output logic [63:0] nx);
        longint off;
        pr = 1'b0;
        nx = p + 64'd4;
        if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
            off = longint'($signed(w[25:0])) * 4;
            pr  = 1'b1;
            nx  = p + 64'(off);
        end else if (BTFN && w[31:24] == 8'h54 && w[23]) begin
            off = longint'($signed(w[23:5])) * 4;
            pr  = 1'b1;
            nx  = p + 64'(off);
        end
    endtask

    task automatic model_step();
        logic [31:0] w;
        logic        pr;
        logic [63:0] nx;
        w = imem[mpc[11:2]];
        if (redir_v) begin
            mq.delete();
            mhalt = 1'b0;
            mpc   = redir_pc;
        end else begin
            if (mq.size() != 0 && dif.in_d_ready) void'(mq.pop_front());
            if (!mhalt && w == 0) mhalt = 1'b1;
            else if (!mhalt && mq.size() < QD) begin
                predict(w, mpc, pr, nx);
                mq.push_back({w, mpc, pr});
                mpc = nx;
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [63:0] p);
        redir_v  = 1'b1;
        redir_pc = p;
        tick();
        redir_v  = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [96:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("m_valid", dif.out_d_valid, mq.size() != 0);
        chk("m_insn", dif.out_d_insnbits, h[96:65]);
        chk("m_pc", dif.out_d_pc, h[64:1]);
        chk("m_pred", dif.out_d_pred_taken, h[0]);
        chk("m_done", dif.out_d_done, mhalt && mq.size() == 0);
        chk("m_imem_addr", imem_addr, mpc);
    end

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = '0;
        for (int i = 0; i < 4; i++) imem[i] = ADD;
        dif.in_d_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", dif.out_d_valid, 0);
        chk("rst_pc", imem_addr, EPC);
        rst_n = 1'b1;
        // sequential code then halt on zero word
        tick(); chk("seq_pc0", dif.out_d_pc, 64'h0);
        tick(); chk("seq_pc4", dif.out_d_pc, 64'h4);
        tick(); chk("seq_pc8", dif.out_d_pc, 64'h8);
        tick(); chk("seq_pcC", dif.out_d_pc, 64'hC);
        chk("seq_done_early", dif.out_d_done, 0);
        tick(); chk("seq_done", dif.out_d_done, 1);
        tick(2); chk("halt_pc_held", imem_addr, 64'h10);
        // B +4 at 0x10, BL -4 at 0x20; redirect out of done state
        imem[4] = 32'h14000004;
        imem[8] = 32'h97FFFFFC;
        redirect(64'h10);
        chk("redir_done_clr", dif.out_d_done, 0);
        tick(); chk("b_pc", dif.out_d_pc, 64'h10); chk("b_pred", dif.out_d_pred_taken, 1);
        tick(); chk("bl_pc", dif.out_d_pc, 64'h20); chk("bl_pred", dif.out_d_pred_taken, 1);
        tick(); chk("bl_tgt", dif.out_d_pc, 64'h10);
        // backpressure
        for (int i = 128; i < 136; i++) imem[i] = ADD;
        dif.in_d_ready = 1'b0;
        redirect(64'h200);
        tick(10);
        chk("bp_valid", dif.out_d_valid, 1);
        chk("bp_head", dif.out_d_pc, 64'h200);
        chk("bp_pc_frozen", imem_addr, 64'h210);
        dif.in_d_ready = 1'b1;
        tick(); chk("drain_1", dif.out_d_pc, 64'h204);
        tick(3); chk("drain_4", dif.out_d_pc, 64'h210);
        tick(8);
        // redirect with three queued entries and a same-cycle pop
        imem[64] = ADD;
        dif.in_d_ready = 1'b0;
        redirect(64'h200);
        tick(3);
        dif.in_d_ready = 1'b1;
        redirect(64'h100);
        chk("redir_flush", dif.out_d_valid, 0);
        tick(); chk("redir_first", dif.out_d_pc, 64'h100);
        tick(2);
        redirect(64'h300);
        redirect(64'h100);
        tick(); chk("redir_last_wins", dif.out_d_pc, 64'h100);
        tick(2);
        // B.cond: imm19=-2 then imm19=+2 at 0x40
        imem[14] = ADD;
        imem[15] = ADD;
        imem[16] = 32'h54FFFFC0;
        imem[17] = 32'h54000040;
        redirect(64'h40);
        tick(); chk("bc_back_pred", dif.out_d_pred_taken, BTFN);
        tick(); chk("bc_back_next", dif.out_d_pc, BTFN ? 64'h38 : 64'h44);
        tick(2);
        imem[16] = 32'h54000040;
        redirect(64'h40);
        tick(); chk("bc_fwd_pred", dif.out_d_pred_taken, 0);
        tick(); chk("bc_fwd_next", dif.out_d_pc, 64'h44);
        tick(3);
        // asynchronous reset with a full FIFO
        dif.in_d_ready = 1'b0;
        redirect(64'h200);
        tick(5);
        chk("full_valid", dif.out_d_valid, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", dif.out_d_valid, 0);
        chk("arst_pc", dif.out_d_pc, 0);
        chk("arst_insn", dif.out_d_insnbits, 0);
        chk("arst_addr", imem_addr, EPC);
        tick();
        rst_n = 1'b1;
        chk("rel_addr", imem_addr, EPC);
        dif.in_d_ready = 1'b1;
        tick(2); chk("rel_resume", dif.out_d_pc, 64'h4);
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
